button_pulse_conditioner: RTL and testbench
===========================================

Name: button_pulse_conditioner

Overview:
- Two-channel front end that sits directly upstream of the Mealy sequence FSM.
- Takes raw, asynchronous, bouncy push-button levels (P1, P2 buttons) and synchronises and debounces them.
- Converts each debounced press into a single-cycle pulse on p1_pulse/p2_pulse, which drive the FSM's P1/P2 inputs.
- Also exports debounced levels and a collision flag for simultaneous presses.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive clk cycles a synchronised level must hold before it is accepted (5 ms at 100 MHz); legal range 1..2^24-1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), counter width; derived, not overridden.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset: 0 = in reset.
- p1_raw  input  1  raw button 1 level, asynchronous, may bounce.
- p2_raw  input  1  raw button 2 level, asynchronous, may bounce.
- p1_pulse  output  1  one-cycle pulse per accepted button-1 press; drives FSM P1.
- p2_pulse  output  1  one-cycle pulse per accepted button-2 press; drives FSM P2.
- p1_level  output  1  debounced button-1 level.
- p2_level  output  1  debounced button-2 level.
- collide  output  1  one-cycle flag: both presses were accepted on the same cycle.

Behaviour:
- Reset (reset=0, asynchronous):
  - Sync flops, counters and internal pulse flops all clear to 0; every output is 0.
  - Both channels start in IDLE_LOW.
  - Deassertion takes effect at the next rising edge.
- Per channel, synchroniser: 2-flop chain, raw -> s1 -> s2. Only s2 feeds the FSM.
- Per channel, states: IDLE_LOW, CHECK_HIGH, IDLE_HIGH, CHECK_LOW. Counter cnt is CNT_W bits.
  - IDLE_LOW: s2=1 -> CHECK_HIGH with cnt<=1. Otherwise stay, cnt<=0.
  - CHECK_HIGH:
    - s2=0 -> IDLE_LOW, cnt<=0 (glitch rejected, no pulse).
    - s2=1 and cnt==DEBOUNCE_CYCLES -> IDLE_HIGH, pulse<=1.
    - Otherwise cnt<=cnt+1.
  - IDLE_HIGH: s2=0 -> CHECK_LOW with cnt<=1. Otherwise stay.
  - CHECK_LOW:
    - s2=1 -> IDLE_HIGH, cnt<=0.
    - s2=0 and cnt==DEBOUNCE_CYCLES -> IDLE_LOW.
    - Otherwise cnt<=cnt+1.
    - Release never produces a pulse.
- Internal pulse flop is 1 only on the cycle after entry to IDLE_HIGH; it is cleared on every other edge.
- level = 1 in IDLE_HIGH and CHECK_LOW, 0 otherwise. It is registered state, not derived from s2.
- Latency: if p1_raw rises just before edge 1 and stays high, p1_pulse is high for exactly the cycle after edge DEBOUNCE_CYCLES+3.
- Holding a button indefinitely gives exactly one pulse. cnt saturates in the stable states and never wraps.
- Output combine is combinational from registered signals and adds no latency:
  - p1_pulse = pulse1 & ~pulse2
  - p2_pulse = pulse2 & ~pulse1
  - collide = pulse1 & pulse2
  - The FSM therefore never sees P1=P2=1.
- Reset mid-CHECK discards the partial count. No pulse is produced for that press, even if the button is still held after reset.
  - After reset release a held button must re-qualify: full DEBOUNCE_CYCLES+3 latency, then one pulse.
- Any bounce inside the window restarts qualification from the stable state.

Decomposition:
- Shared package: state encoding typedef (IDLE_LOW=2'b00, CHECK_HIGH=2'b01, IDLE_HIGH=2'b11, CHECK_LOW=2'b10) and the default DEBOUNCE_CYCLES constant.
- One sub-module, btn_debounce_channel (sync + FSM + counter + pulse flop), instantiated twice.
- The top holds only the collision combine.

Test Plan (DEBOUNCE_CYCLES=4, 10 ns clk, reset low for 15 ns):
- Clean press: p1_raw 0->1 before edge 1 and held -> p1_pulse=1 for one cycle after edge 7; p1_level=1 from edge 7; p2_pulse and collide stay 0.
- Glitch: p1_raw high for 2 cycles, then low -> no p1_pulse; p1_level stays 0.
- Bounce then stable: p2_raw toggles 1,0,1,0 per cycle, then holds 1 -> exactly one p2_pulse, 7 edges after the final rise.
- Hold and release: p1_raw high for 30 cycles, then low for 10 -> one pulse only; p1_level returns to 0 at 7 edges after the fall.
- Simultaneous: p1_raw and p2_raw rise on the same cycle -> collide=1 for one cycle after edge 7; p1_pulse=p2_pulse=0.
- Reset mid-operation: reset=0 at edge 5 of a p1 press held through the end of reset -> all outputs 0 during reset; after release exactly one pulse, 7 edges after the first edge with reset=1.

Source files
------------

// File: rtl/button_pulse_conditioner_pkg.sv
// Shared types and constants for the two-channel button front end.
// Contents: debounce state encoding and the default qualification window.
package button_pulse_conditioner_pkg;

    // Bit 1 of the encoding is the accepted (debounced) level.
    typedef enum logic [1:0] {
        IDLE_LOW   = 2'b00,
        CHECK_HIGH = 2'b01,
        IDLE_HIGH  = 2'b11,
        CHECK_LOW  = 2'b10
    } deb_state_t;

    // 5 ms at 100 MHz.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 32'd500000;

endpackage

// File: rtl/button_pulse_conditioner_if.sv
// Button front-end bus: raw button levels in, conditioned pulses/levels out.
// Signals:
//   p1_raw, p2_raw     raw asynchronous button levels (driven by master)
//   p1_pulse, p2_pulse one-cycle press pulses, never both high
//   p1_level, p2_level debounced levels
//   collide            both presses accepted on the same cycle
interface button_pulse_conditioner_if;

    logic p1_raw;
    logic p2_raw;
    logic p1_pulse;
    logic p2_pulse;
    logic p1_level;
    logic p2_level;
    logic collide;

    modport master (
        output p1_raw, p2_raw,
        input  p1_pulse, p2_pulse, p1_level, p2_level, collide
    );

    modport slave (
        input  p1_raw, p2_raw,
        output p1_pulse, p2_pulse, p1_level, p2_level, collide
    );

endinterface

// File: rtl/button_pulse_conditioner_channel.sv
// One button channel: 2-flop synchroniser, debounce FSM with qualification
// counter, and a one-cycle press pulse flop.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   raw    raw button level (asynchronous, bouncy)
//   pulse  one cycle high after a press is accepted
//   level  debounced level (registered state)
module btn_debounce_channel
    import button_pulse_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic pulse,
    output logic level
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1;
    logic             s2;
    deb_state_t       state;
    deb_state_t       state_d;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             pulse_d;

    // Synchroniser; only s2 is seen by the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // State, counter and pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE_LOW;
            cnt   <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            pulse <= pulse_d;
        end
    end

    // Next state; any opposite sample inside a check window falls back to the stable state.
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        pulse_d = 1'b0;
        case (state)
            IDLE_LOW: begin
                if (s2) begin
                    state_d = CHECK_HIGH;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d   = '0;
                end
            end
            CHECK_HIGH: begin
                if (!s2) begin
                    state_d = IDLE_LOW;
                    cnt_d   = '0;
                end else if (cnt == CNT_DONE) begin
                    state_d = IDLE_HIGH;
                    pulse_d = 1'b1;
                end else begin
                    cnt_d   = cnt + CNT_ONE;
                end
            end
            IDLE_HIGH: begin
                if (!s2) begin
                    state_d = CHECK_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            CHECK_LOW: begin
                if (s2) begin
                    state_d = IDLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt == CNT_DONE) begin
                    state_d = IDLE_LOW;
                end else begin
                    cnt_d   = cnt + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // Level is high in IDLE_HIGH and CHECK_LOW, i.e. state bit 1.
    assign level = state[1];

endmodule

// File: rtl/button_pulse_conditioner.sv
// Two-channel push-button conditioner feeding the sequence FSM's P1/P2 inputs.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    slave side of the button bus (raw levels in; pulses, levels,
//          collision flag out)
module button_pulse_conditioner
    import button_pulse_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    button_pulse_conditioner_if.slave     bus
);

    logic pulse1;
    logic pulse2;
    logic level1;
    logic level2;

    btn_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch1 (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.p1_raw),
        .pulse (pulse1),
        .level (level1)
    );

    btn_debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ch2 (
        .clk   (clk),
        .reset (reset),
        .raw   (bus.p2_raw),
        .pulse (pulse2),
        .level (level2)
    );

    // Simultaneous presses are reported as a collision so the FSM never sees P1=P2=1.
    assign bus.p1_pulse = pulse1 & ~pulse2;
    assign bus.p2_pulse = pulse2 & ~pulse1;
    assign bus.collide  = pulse1 & pulse2;
    assign bus.p1_level = level1;
    assign bus.p2_level = level2;

endmodule

// File: tb/tb_button_pulse_conditioner.sv
// Scoreboard bench for button_pulse_conditioner (DEBOUNCE_CYCLES = 4).
// A run-length reference model predicts pulse events into a queue; a negedge
// monitor pops and compares them, and checks debounced levels every cycle.
module tb_button_pulse_conditioner;

    localparam int DC  = 4;
    localparam int LAT = DC + 3;

    logic clk;
    logic reset;

    button_pulse_conditioner_if bus();

    button_pulse_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int         cyc;
        logic [2:0] kind;   // {collide, p2_pulse, p1_pulse}
    } evt_t;

    evt_t exp_q[$];

    int n_pass;
    int n_total;
    int cyc;

    // Reference model state: 2-deep delay line, accepted level, opposite-run length.
    bit m_d1  [2];
    bit m_d2  [2];
    bit m_lvl [2];
    int m_run [2];

    // Monitor bookkeeping for directed checks.
    int n_p1, n_p2, n_col;
    int last_p1, last_p2, last_col;
    int l1_rise, l1_fall;
    bit prev_l1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, exp);
    endtask

    // Model: a level is accepted once DC+1 consecutive synchronised samples oppose it.
    always @(posedge clk) begin
        bit   rise [2];
        bit   raw_v [2];
        bit   s;
        evt_t e;
        cyc++;
        raw_v[0] = bus.p1_raw;
        raw_v[1] = bus.p2_raw;
        for (int ch = 0; ch < 2; ch++) begin
            rise[ch] = 1'b0;
            if (!reset) begin
                m_d1[ch]  = 1'b0;
                m_d2[ch]  = 1'b0;
                m_lvl[ch] = 1'b0;
                m_run[ch] = 0;
            end else begin
                s         = m_d2[ch];
                m_d2[ch]  = m_d1[ch];
                m_d1[ch]  = raw_v[ch];
                m_run[ch] = (s != m_lvl[ch]) ? m_run[ch] + 1 : 0;
                if (m_run[ch] == DC + 1) begin
                    m_lvl[ch] = ~m_lvl[ch];
                    m_run[ch] = 0;
                    rise[ch]  = m_lvl[ch];
                end
            end
        end
        e.cyc = cyc;
        if (rise[0] && rise[1]) begin
            e.kind = 3'b100;
            exp_q.push_back(e);
        end else if (rise[0]) begin
            e.kind = 3'b001;
            exp_q.push_back(e);
        end else if (rise[1]) begin
            e.kind = 3'b010;
            exp_q.push_back(e);
        end
    end

    // Monitor: sample away from the active edge.
    always @(negedge clk) begin
        logic [2:0] got;
        got = {bus.collide, bus.p2_pulse, bus.p1_pulse};
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            check("pulse_missed", 0, int'(exp_q[0].kind));
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            check("pulse_kind", int'(got), int'(exp_q[0].kind));
            void'(exp_q.pop_front());
        end else begin
            check("no_pulse", int'(got), 0);
        end
        check("p1_level", int'(bus.p1_level), int'(m_lvl[0]));
        check("p2_level", int'(bus.p2_level), int'(m_lvl[1]));
        if (!reset)
            check("reset_outputs", int'({got, bus.p2_level, bus.p1_level}), 0);
        if (got == 3'b001) begin n_p1++;  last_p1  = cyc; end
        if (got == 3'b010) begin n_p2++;  last_p2  = cyc; end
        if (got == 3'b100) begin n_col++; last_col = cyc; end
        if (bus.p1_level && !prev_l1) l1_rise = cyc;
        if (!bus.p1_level && prev_l1) l1_fall = cyc;
        prev_l1 = bus.p1_level;
    end

    task automatic step(input bit a, input bit b);
        @(negedge clk);
        #1;
        bus.p1_raw = a;
        bus.p2_raw = b;
    endtask

    task automatic hold(input bit a, input bit b, input int n);
        repeat (n) step(a, b);
    endtask

    task automatic set_rst(input logic v);
        @(negedge clk);
        #1;
        reset = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int s, r, n1, n2, nc, len1, len2;
        bit a, b;
        n_pass = 0; n_total = 0; cyc = 0;
        n_p1 = 0; n_p2 = 0; n_col = 0;
        last_p1 = -1; last_p2 = -1; last_col = -1;
        l1_rise = -1; l1_fall = -1; prev_l1 = 1'b0;
        reset = 1'b0;
        bus.p1_raw = 1'b0;
        bus.p2_raw = 1'b0;
        repeat (2) @(negedge clk);
        #1 reset = 1'b1;
        hold(0, 0, 3);

        // Clean press, long hold, then release.
        n1 = n_p1; n2 = n_p2; nc = n_col;
        step(1, 0); s = cyc;
        hold(1, 0, 29);
        check("clean_latency", last_p1, s + LAT);
        check("clean_level_rise", l1_rise, s + LAT);
        check("clean_single_pulse", n_p1 - n1, 1);
        check("clean_no_other", (n_p2 - n2) + (n_col - nc), 0);
        step(0, 0); s = cyc;
        hold(0, 0, 9);
        check("release_level_fall", l1_fall, s + LAT);
        check("release_no_pulse", n_p1 - n1, 1);

        // Short glitch is rejected.
        n1 = n_p1; r = l1_rise;
        hold(1, 0, 2);
        hold(0, 0, 10);
        check("glitch_no_pulse", n_p1 - n1, 0);
        check("glitch_no_level", l1_rise, r);

        // Bounce on p2 then stable high.
        n2 = n_p2;
        step(0, 1); step(0, 0); step(0, 1); step(0, 0); step(0, 1); s = cyc;
        hold(0, 1, 11);
        check("bounce_latency", last_p2, s + LAT);
        check("bounce_single_pulse", n_p2 - n2, 1);
        hold(0, 0, 10);

        // Simultaneous press.
        n1 = n_p1; n2 = n_p2; nc = n_col;
        step(1, 1); s = cyc;
        hold(1, 1, 11);
        check("collide_latency", last_col, s + LAT);
        check("collide_once", n_col - nc, 1);
        check("collide_no_single", (n_p1 - n1) + (n_p2 - n2), 0);
        hold(0, 0, 10);

        // Reset in the middle of qualification, button still held.
        n1 = n_p1;
        step(1, 0);
        hold(1, 0, 3);
        set_rst(1'b0);
        hold(1, 0, 2);
        check("reset_discards_press", n_p1 - n1, 0);
        set_rst(1'b1); r = cyc;
        hold(1, 0, 11);
        check("requalify_latency", last_p1, r + LAT);
        check("requalify_once", n_p1 - n1, 1);
        hold(0, 0, 10);

        // Randomised run lengths around the qualification window, rare resets.
        a = 1'b0; b = 1'b0; len1 = 0; len2 = 0;
        for (int i = 0; i < 600; i++) begin
            if (len1 == 0) begin a = ~a; len1 = int'($urandom_range(1, 12)); end
            if (len2 == 0) begin b = ~b; len2 = int'($urandom_range(1, 12)); end
            len1--;
            len2--;
            @(negedge clk);
            #1;
            bus.p1_raw = a;
            bus.p2_raw = b;
            reset = ($urandom_range(0, 249) != 0);
        end
        set_rst(1'b1);
        hold(0, 0, 20);
        check("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
